// File: rtl/dram_arbiter.sv
// Single-port DRAM command arbiter: refresh, write-capture and read-display
// requesters share one controller interface, one command in flight at a time.
module dram_arbiter #(
  parameter int REF_INTERVAL  = 780,
  parameter int TIMEOUT       = 255,
  parameter int WR_STREAK_MAX = 4
) (
  input  logic        CLK100MHz,
  input  logic        resetN,
  input  logic        wrReq,
  input  logic        rdReq,
  input  logic [12:0] wrRow,
  input  logic [12:0] rdRow,
  input  logic [1:0]  wrBank,
  input  logic [1:0]  rdBank,
  input  logic        rdUrgent,
  output logic        wrDone,
  output logic        rdDone,
  output logic        DRAMWriteReq,
  output logic        DRAMReadReq,
  output logic        DRAMRefreshReq,
  output logic [12:0] rowAddress,
  output logic [1:0]  bankAddress,
  input  logic        DRAMWriteAck,
  input  logic        DRAMReadAck,
  input  logic        DRAMRefreshAck,
  output logic        busy,
  output logic        ackTimeout,
  output logic        refOverrun
);

  localparam int RW = $clog2(REF_INTERVAL + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, REFRESH} state_t;

  state_t        state;
  logic [RW-1:0] ref_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [2:0]    wr_streak;
  logic          ref_pending;
  logic          ready;
  logic          ref_expire;
  logic          ref_req;
  logic          rd_first;
  logic          ack_hit;
  logic          tmo_hit;

  // An expiry in the current IDLE cycle already counts as a refresh request,
  // so a simultaneous write/read request loses to it.
  assign ref_expire = (ref_cnt == '0);
  assign ref_req    = ref_pending | ref_expire;
  assign rd_first   = rdReq & (rdUrgent | (wr_streak == 3'(WR_STREAK_MAX)));
  assign ack_hit    = ((state == WRITE)   & DRAMWriteAck) |
                      ((state == READ)    & DRAMReadAck)  |
                      ((state == REFRESH) & DRAMRefreshAck);
  assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT - 1));
  assign busy       = (state != IDLE);

  always_ff @(posedge CLK100MHz or negedge resetN) begin
    if (!resetN) begin
      state          <= IDLE;
      ref_cnt        <= RW'(REF_INTERVAL - 1);
      tmo_cnt        <= '0;
      wr_streak      <= '0;
      ref_pending    <= 1'b0;
      ready          <= 1'b0;
      wrDone         <= 1'b0;
      rdDone         <= 1'b0;
      DRAMWriteReq   <= 1'b0;
      DRAMReadReq    <= 1'b0;
      DRAMRefreshReq <= 1'b0;
      rowAddress     <= '0;
      bankAddress    <= '0;
      ackTimeout     <= 1'b0;
      refOverrun     <= 1'b0;
    end else begin
      // ready holds off grants for the first edge after reset release
      ready  <= 1'b1;
      wrDone <= 1'b0;
      rdDone <= 1'b0;
      ref_cnt <= ref_expire ? RW'(REF_INTERVAL - 1) : ref_cnt - 1'b1;
      if (ref_expire) begin
        if (ref_pending) refOverrun <= 1'b1;
        ref_pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (!rdReq) wr_streak <= '0;
          if (ready) begin
            tmo_cnt <= '0;
            if (ref_req) begin
              state          <= REFRESH;
              DRAMRefreshReq <= 1'b1;
              ref_pending    <= 1'b0;
            end else if (rd_first || (rdReq && !wrReq)) begin
              state       <= READ;
              DRAMReadReq <= 1'b1;
              rowAddress  <= rdRow;
              bankAddress <= rdBank;
              wr_streak   <= '0;
            end else if (wrReq) begin
              state        <= WRITE;
              DRAMWriteReq <= 1'b1;
              rowAddress   <= wrRow;
              bankAddress  <= wrBank;
              if (rdReq && wr_streak != 3'd7) wr_streak <= wr_streak + 1'b1;
            end
          end
        end
        default: begin
          if (ack_hit) begin
            state          <= IDLE;
            DRAMWriteReq   <= 1'b0;
            DRAMReadReq    <= 1'b0;
            DRAMRefreshReq <= 1'b0;
            wrDone         <= (state == WRITE);
            rdDone         <= (state == READ);
          end else if (tmo_hit) begin
            // requester keeps its request up, so the command is simply retried
            state          <= IDLE;
            DRAMWriteReq   <= 1'b0;
            DRAMReadReq    <= 1'b0;
            DRAMRefreshReq <= 1'b0;
            ackTimeout     <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: a cycle vector table for the basic
// handshakes, then hand sequences for streaks, refresh, timeout and reset.
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_req, rd_req, rd_urg;
  logic [12:0] wr_row, rd_row;
  logic [1:0]  wr_bank, rd_bank;
  logic        wr_done, rd_done;
  logic        w_req, r_req, f_req;
  logic [12:0] row_addr;
  logic [1:0]  bank_addr;
  logic        w_ack, r_ack, f_ack;
  logic        busy, ack_tmo, ref_ovr;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dram_arbiter #(.REF_INTERVAL(100), .TIMEOUT(255), .WR_STREAK_MAX(4)) dut (
    .CLK100MHz(clk), .resetN(rst_n),
    .wrReq(wr_req), .rdReq(rd_req),
    .wrRow(wr_row), .rdRow(rd_row), .wrBank(wr_bank), .rdBank(rd_bank),
    .rdUrgent(rd_urg),
    .wrDone(wr_done), .rdDone(rd_done),
    .DRAMWriteReq(w_req), .DRAMReadReq(r_req), .DRAMRefreshReq(f_req),
    .rowAddress(row_addr), .bankAddress(bank_addr),
    .DRAMWriteAck(w_ack), .DRAMReadAck(r_ack), .DRAMRefreshAck(f_ack),
    .busy(busy), .ackTimeout(ack_tmo), .refOverrun(ref_ovr)
  );

  // {wreq, rreq, fref, wdone, rdone, busy, ackTimeout, refOverrun, row, bank}
  logic [22:0] obs;
  assign obs = {w_req, r_req, f_req, wr_done, rd_done, busy, ack_tmo, ref_ovr,
                row_addr, bank_addr};

  typedef struct {
    logic [5:0]  in;   // {wr_req, rd_req, rd_urg, w_ack, r_ack, f_ack}
    logic [4:0]  o;    // {wreq, rreq, wdone, rdone, busy}
    logic [12:0] row;
    logic [1:0]  bank;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic [5:0] in, input logic [4:0] o,
                              input logic [12:0] row, input logic [1:0] bank);
    vec_t v;
    v.in = in; v.o = o; v.row = row; v.bank = bank;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    wr_req = 0; rd_req = 0; rd_urg = 0; w_ack = 0; r_ack = 0; f_ack = 0;
  endtask

  // releases reset on a falling edge; the next rising edge is edge 1
  task automatic do_reset();
    rst_n = 1'b0;
    clr_in();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int g[10];
    int ng, cnt, lows;
    logic pw, pr, seen_done, found;

    wr_row = 13'h1A5; wr_bank = 2'd2; rd_row = 13'h0C3; rd_bank = 2'd1;

    tbl[0]  = mk(6'b100000, 5'b00000, 13'h000, 2'd0);  // first edge: no grant yet
    tbl[1]  = mk(6'b100000, 5'b10001, 13'h1A5, 2'd2);
    tbl[2]  = mk(6'b100000, 5'b10001, 13'h1A5, 2'd2);
    tbl[3]  = mk(6'b100000, 5'b10001, 13'h1A5, 2'd2);
    tbl[4]  = mk(6'b100000, 5'b10001, 13'h1A5, 2'd2);
    tbl[5]  = mk(6'b100000, 5'b10001, 13'h1A5, 2'd2);
    tbl[6]  = mk(6'b100100, 5'b00100, 13'h1A5, 2'd2);
    tbl[7]  = mk(6'b000000, 5'b00000, 13'h1A5, 2'd2);
    tbl[8]  = mk(6'b111000, 5'b01001, 13'h0C3, 2'd1);  // urgent read beats write
    tbl[9]  = mk(6'b111010, 5'b00010, 13'h0C3, 2'd1);
    tbl[10] = mk(6'b100000, 5'b10001, 13'h1A5, 2'd2);
    tbl[11] = mk(6'b100100, 5'b00100, 13'h1A5, 2'd2);
    tbl[12] = mk(6'b000000, 5'b00000, 13'h1A5, 2'd2);
    tbl[13] = mk(6'b000111, 5'b00000, 13'h1A5, 2'd2);  // acks in IDLE ignored
    tbl[14] = mk(6'b100000, 5'b10001, 13'h1A5, 2'd2);
    tbl[15] = mk(6'b000010, 5'b10001, 13'h1A5, 2'd2);  // wrong ack, request dropped
    tbl[16] = mk(6'b000100, 5'b00100, 13'h1A5, 2'd2);
    tbl[17] = mk(6'b000000, 5'b00000, 13'h1A5, 2'd2);

    // reset state
    rst_n = 1'b0;
    clr_in();
    repeat (2) @(negedge clk);
    check("reset_state", 32'(obs), 32'h0);

    // table
    do_reset();
    for (int i = 0; i < 18; i++) begin
      {wr_req, rd_req, rd_urg, w_ack, r_ack, f_ack} = tbl[i].in;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(obs),
            32'({tbl[i].o[4:3], 1'b0, tbl[i].o[2:0], 2'b00, tbl[i].row, tbl[i].bank}));
    end
    clr_in();

    // write streak: continuous wr+rd gives WWWWR WWWWR
    do_reset();
    wr_req = 1; rd_req = 1;
    ng = 0; pw = 0; pr = 0;
    for (int c = 0; c < 100 && ng < 10; c++) begin
      @(negedge clk);
      if (w_req && !pw) begin g[ng] = 1; ng++; end
      else if (r_req && !pr) begin g[ng] = 2; ng++; end
      pw = w_req; pr = r_req;
      w_ack = w_req; r_ack = r_req; f_ack = f_req;
    end
    check("streak_grants", 32'(ng), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < ng) check($sformatf("grant%0d", i), 32'(g[i]), (i % 5 == 4) ? 32'd2 : 32'd1);
    clr_in();

    // refresh expiry (edge 100) during a read wins over a waiting write
    do_reset();
    repeat (91) @(negedge clk);
    rd_req = 1;
    @(negedge clk);
    check("rd_grant", 32'({r_req, busy}), 32'b11);
    wr_req = 1;
    repeat (10) @(negedge clk);
    r_ack = 1;
    @(negedge clk);
    check("rd_done", 32'({r_req, rd_done, busy}), 32'b010);
    r_ack = 0; rd_req = 0;
    @(negedge clk);
    check("ref_after_rd", 32'({f_req, w_req, row_addr, bank_addr}), 32'({2'b10, 13'h0C3, 2'd1}));
    f_ack = 1;
    @(negedge clk);
    check("ref_no_done", 32'({f_req, wr_done, rd_done, busy}), 32'h0);
    f_ack = 0;
    @(negedge clk);
    check("wr_after_ref", 32'({w_req, row_addr, bank_addr}), 32'({1'b1, 13'h1A5, 2'd2}));
    w_ack = 1;
    @(negedge clk);
    clr_in();
    @(negedge clk);

    // read ack withheld: 255-cycle timeout then retry
    do_reset();
    rd_req = 1;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      found = r_req;
    end
    check("tmo_grant", 32'(found), 32'd1);
    cnt = found ? 1 : 0;
    seen_done = 0;
    for (int c = 0; c < 400 && found; c++) begin
      @(negedge clk);
      if (rd_done) seen_done = 1;
      if (!r_req) break;
      cnt++;
    end
    check("rd_hold_cycles", 32'(cnt), 32'd255);
    check("tmo_flags", 32'({ack_tmo, seen_done, busy}), 32'b100);
    check("tmo_overrun", 32'(ref_ovr), 32'd1);
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      f_ack = f_req;
      found = r_req;
    end
    check("rd_regrant", 32'(found), 32'd1);
    f_ack = 0; r_ack = 1;
    @(negedge clk);
    clr_in();

    // refresh ack withheld across two more expiries, then async reset
    do_reset();
    found = 0;
    for (int c = 0; c < 150 && !found; c++) begin
      @(negedge clk);
      found = f_req;
    end
    check("ref_grant", 32'(found), 32'd1);
    lows = 0;
    repeat (150) begin
      @(negedge clk);
      if (!f_req) lows++;
    end
    check("ovr_early", 32'(ref_ovr), 32'd0);
    repeat (60) begin
      @(negedge clk);
      if (!f_req) lows++;
    end
    check("ovr_set", 32'({ref_ovr, f_req, busy}), 32'b111);
    check("ref_single", 32'(lows), 32'd0);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'(obs), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 The block SHALL have parameter REF_INTERVAL, default 780, meaning refresh period in clock cycles (7.8 us at 100 MHz).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles to wait for a DRAM acknowledge.
REQ-003 The block SHALL have parameter WR_STREAK_MAX, default 4, meaning the number of consecutive writes allowed while a read waits.
REQ-004 The block SHALL have port CLK100MHz  input  1  single clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port resetN  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have ports wrReq/rdReq  input  1  write/read requests from the capture and display paths; held high until the matching done pulse.
REQ-007 The block SHALL have ports wrRow/rdRow  input  13  and  wrBank/rdBank  input  2  addresses, stable while the request is high.
REQ-008 The block SHALL have port rdUrgent  input  1  display FIFO below its low-water mark.
REQ-009 The block SHALL have ports wrDone/rdDone  output  1  one-cycle completion pulses.
REQ-010 The block SHALL have ports DRAMWriteReq, DRAMReadReq, DRAMRefreshReq  output  1  commands to the DRAM controller.
REQ-011 The block SHALL have ports rowAddress  output  13  and  bankAddress  output  2  latched command address.
REQ-012 The block SHALL have ports DRAMWriteAck, DRAMReadAck, DRAMRefreshAck  input  1  one-cycle completion acknowledges from the DRAM controller.
REQ-013 The block SHALL have ports busy  output  1  (state != IDLE), ackTimeout  output  1  (sticky), refOverrun  output  1  (sticky).

Function
REQ-014 The FSM SHALL have the states IDLE, WRITE, READ and REFRESH; a grant SHALL be issued only from IDLE.
REQ-015 In IDLE, the grant priority SHALL be: refPending > (rdReq & rdUrgent) > (rdReq & wrStreak==WR_STREAK_MAX) > wrReq > rdReq.
REQ-016 A request seen in IDLE at cycle N SHALL cause the state change, a registered DRAM*Req high and a latched row/bank address at N+1 (1-cycle grant latency).
REQ-017 DRAM*Req SHALL remain high until the matching ack is sampled; at the ack cycle M+1, Req SHALL go low, wrDone/rdDone SHALL pulse, and the state SHALL return to IDLE; the earliest next grant is M+2.
REQ-018 A refresh SHALL produce no done pulse.
REQ-019 rowAddress and bankAddress SHALL hold their last value outside transactions and SHALL change only on a grant; a refresh SHALL leave them unchanged.
REQ-020 Acks for a non-active command, or acks received in IDLE, SHALL be ignored.
REQ-021 wrStreak (3 bits, saturating) SHALL increment on each write grant while rdReq is high, and SHALL clear on any read grant or whenever rdReq is low in IDLE.
REQ-022 The refresh counter SHALL count down from REF_INTERVAL-1; at 0 it SHALL reload and set refPending; refPending SHALL clear on the refresh grant.
REQ-023 A counter expiry while refPending is already set SHALL set refOverrun; no second refresh SHALL be queued.
REQ-024 The timeout counter SHALL reset on every grant; if no ack arrives within TIMEOUT cycles of the grant, the block SHALL drop Req, return to IDLE without a done pulse and set ackTimeout.
REQ-025 The requester SHALL keep its request high after a timeout, so the command is retried.
REQ-026 A request deasserted mid-transaction SHALL NOT abort the transaction.
REQ-027 When a request and a refresh expiry occur in the same IDLE cycle, the refresh SHALL win.

Reset
REQ-028 While resetN=0, the block SHALL hold state IDLE, all Req/done outputs 0, rowAddress 0, bankAddress 0, wrStreak 0, refPending 0, ackTimeout 0 and refOverrun 0, with the refresh counter set to REF_INTERVAL-1.
REQ-029 Reset asserted mid-transaction SHALL drop DRAM*Req asynchronously; the first grant is possible on the second clock edge after resetN rises.

Verification
REQ-030 The bench SHALL apply wrReq with wrRow=0x1A5, wrBank=2 in IDLE and assert DRAMWriteAck 5 cycles later -> DRAMWriteReq high for 5 cycles, rowAddress=0x1A5, bankAddress=2, a single wrDone pulse, and busy low again.
REQ-031 The bench SHALL hold wrReq and rdReq continuously with rdUrgent=0 -> the grant pattern is 4 writes, 1 read, 4 writes, 1 read.
REQ-032 The bench SHALL assert rdUrgent together with wrReq in IDLE -> the read is granted first.
REQ-033 The bench SHALL let the refresh counter expire during a read and delay the ack by 10 cycles -> REFRESH follows the read before the pending write, with no done pulse for the refresh.
REQ-034 The bench SHALL withhold DRAMReadAck -> DRAMReadReq drops after 255 cycles, ackTimeout=1, no rdDone, and the read is re-granted while rdReq stays high.
REQ-035 The bench SHALL block DRAMRefreshAck across two expiries -> refOverrun=1 and exactly one refresh is outstanding; then it SHALL pulse resetN low mid-transaction -> all outputs return to their reset values immediately.
